// File: rtl/block_ram_arbiter_if.sv
// block_ram_arbiter_if: CPU, VGA and BlockRAM signals of the arbiter.
// master drives requests and RAM read data; slave is the arbiter.
interface block_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vga_req, vga_addr, ram_dataOut,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  ram_wEn, ram_addr, ram_dataIn
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vga_req, vga_addr, ram_dataOut,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output vga_gnt, vga_rvalid, vga_rdata,
    output ram_wEn, ram_addr, ram_dataIn
  );
endinterface

// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: CPU/VGA arbiter for one single-port BlockRAM.
// Define VGA_PRIORITY_EN for VGA-first ties with CPU anti-starvation.
module block_ram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clock,
  input  logic               reset,
  block_ram_arbiter_if.slave bus
);

  logic              cpu_gnt;
  logic              vga_gnt;
  logic              cpu_tie;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_pend;
  logic              vga_pend;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] vga_hold;

`ifdef VGA_PRIORITY_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // CPU only wins a tie once it has been denied STARVE_MAX times in a row
  assign cpu_tie = (starve_cnt >= CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.cpu_req || cpu_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt < CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  typedef enum logic {
    WIN_CPU,
    WIN_VGA
  } winner_t;

  winner_t last_winner;

  assign cpu_tie = (last_winner == WIN_VGA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_winner <= WIN_VGA;
    end else if (cpu_gnt) begin
      last_winner <= WIN_CPU;
    end else if (vga_gnt) begin
      last_winner <= WIN_VGA;
    end
  end
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (!reset) begin
      if (bus.cpu_req && bus.vga_req) begin
        cpu_gnt = cpu_tie;
        vga_gnt = !cpu_tie;
      end else begin
        cpu_gnt = bus.cpu_req;
        vga_gnt = bus.vga_req;
      end
    end
  end

  // Address and write data hold their last value when idle
  always_comb begin
    ram_addr = addr_q;
    if (cpu_gnt) begin
      ram_addr = bus.cpu_addr;
    end else if (vga_gnt) begin
      ram_addr = bus.vga_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_pend <= 1'b0;
      vga_pend <= 1'b0;
      cpu_hold <= '0;
      vga_hold <= '0;
    end else begin
      cpu_pend <= cpu_gnt & ~bus.cpu_we;
      vga_pend <= vga_gnt;
      if (cpu_gnt || vga_gnt) begin
        addr_q <= ram_addr;
      end
      if (cpu_gnt) begin
        wdata_q <= bus.cpu_wdata;
      end
      if (cpu_pend) begin
        cpu_hold <= bus.ram_dataOut;
      end
      if (vga_pend) begin
        vga_hold <= bus.ram_dataOut;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.ram_wEn    = cpu_gnt & bus.cpu_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_dataIn = cpu_gnt ? bus.cpu_wdata : wdata_q;
  assign bus.cpu_rvalid = cpu_pend;
  assign bus.vga_rvalid = vga_pend;
  assign bus.cpu_rdata  = cpu_pend ? bus.ram_dataOut : cpu_hold;
  assign bus.vga_rdata  = vga_pend ? bus.ram_dataOut : vga_hold;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb_block_ram_arbiter: directed bench with a BlockRAM model and a
// cycle-by-cycle reference model of the arbiter.
module tb_block_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  block_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  block_ram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == AW'(5)) ? 32'h1234 : 32'h1000 + 32'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BlockRAM: registered read, one clock after the address
  logic [DW-1:0] ram_mem [1024];
  bit            ram_wr  [1024];

  always @(posedge clk) begin
    if (bus.ram_wEn) begin
      ram_mem[bus.ram_addr] <= bus.ram_dataIn;
      ram_wr[bus.ram_addr]  <= 1'b1;
    end
    bus.ram_dataOut <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr]
                                            : init_val(bus.ram_addr);
  end

  // Reference model
  logic [DW-1:0] sh_mem [1024];
  bit            sh_wr  [1024];
  bit            m_last_vga = 1'b1;
  int            m_starve = 0;
  logic [AW-1:0] m_last_addr = '0;
  bit            m_cpu_pend = 1'b0;
  bit            m_vga_pend = 1'b0;
  logic [DW-1:0] m_cpu_data = '0;
  logic [DW-1:0] m_vga_data = '0;
  logic [DW-1:0] m_cpu_hold = '0;
  logic [DW-1:0] m_vga_hold = '0;

  always @(negedge clk) begin : model
    bit            gc;
    bit            gv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ecd;
    logic [DW-1:0] evd;
    gc = 1'b0;
    gv = 1'b0;
    if (rst) begin
      check("rst_cpu_gnt", bus.cpu_gnt, 0);
      check("rst_vga_gnt", bus.vga_gnt, 0);
      check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
      check("rst_vga_rvalid", bus.vga_rvalid, 0);
      check("rst_ram_wEn", bus.ram_wEn, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_cpu_rdata", bus.cpu_rdata, 0);
      check("rst_vga_rdata", bus.vga_rdata, 0);
      m_last_vga  = 1'b1;
      m_starve    = 0;
      m_last_addr = '0;
      m_cpu_pend  = 1'b0;
      m_vga_pend  = 1'b0;
      m_cpu_hold  = '0;
      m_vga_hold  = '0;
    end else begin
      if (bus.cpu_req && bus.vga_req) begin
`ifdef VGA_PRIORITY_EN
        if (m_starve >= SMAX) gc = 1'b1;
        else gv = 1'b1;
`else
        if (m_last_vga) gc = 1'b1;
        else gv = 1'b1;
`endif
      end else begin
        gc = bus.cpu_req;
        gv = bus.vga_req;
      end
      ea  = gc ? bus.cpu_addr : (gv ? bus.vga_addr : m_last_addr);
      ecd = m_cpu_pend ? m_cpu_data : m_cpu_hold;
      evd = m_vga_pend ? m_vga_data : m_vga_hold;
      check("cpu_gnt", bus.cpu_gnt, gc);
      check("vga_gnt", bus.vga_gnt, gv);
      check("ram_wEn", bus.ram_wEn, gc && bus.cpu_we);
      check("ram_addr", bus.ram_addr, ea);
      if (gc && bus.cpu_we) check("ram_dataIn", bus.ram_dataIn, bus.cpu_wdata);
      check("cpu_rvalid", bus.cpu_rvalid, m_cpu_pend);
      check("vga_rvalid", bus.vga_rvalid, m_vga_pend);
      check("cpu_rdata", bus.cpu_rdata, ecd);
      check("vga_rdata", bus.vga_rdata, evd);
      m_cpu_hold = ecd;
      m_vga_hold = evd;
      m_cpu_pend = gc && !bus.cpu_we;
      m_vga_pend = gv;
      m_cpu_data = sh_wr[bus.cpu_addr] ? sh_mem[bus.cpu_addr]
                                       : init_val(bus.cpu_addr);
      m_vga_data = sh_wr[bus.vga_addr] ? sh_mem[bus.vga_addr]
                                       : init_val(bus.vga_addr);
      if (gc && bus.cpu_we) begin
        sh_mem[bus.cpu_addr] = bus.cpu_wdata;
        sh_wr[bus.cpu_addr]  = 1'b1;
      end
      if (bus.cpu_req && !gc) m_starve++;
      else m_starve = 0;
      if (gc) m_last_vga = 1'b0;
      if (gv) m_last_vga = 1'b1;
      m_last_addr = ea;
    end
  end

  task automatic idle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input int a);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = AW'(a);
  endtask

  task automatic vga_rd(input int a);
    bus.vga_req  = 1'b1;
    bus.vga_addr = AW'(a);
  endtask

  logic [9:0] pat;
  logic [9:0] exp_pat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    cpu_rd(5);
    vga_rd(6);
    @(negedge clk);
    check("rst_gated_cpu_gnt", bus.cpu_gnt, 0);
    check("rst_gated_vga_gnt", bus.vga_gnt, 0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    cpu_rd(5);
    @(negedge clk);
    check("rd5_gnt", bus.cpu_gnt, 1);
    check("rd5_addr", bus.ram_addr, 5);
    tick();
    idle();
    @(negedge clk);
    check("rd5_rvalid", bus.cpu_rvalid, 1);
    check("rd5_rdata", bus.cpu_rdata, 32'h1234);
    tick();
    @(negedge clk);
    check("rd5_hold", bus.cpu_rdata, 32'h1234);
    check("idle_addr_hold", bus.ram_addr, 5);

    tick();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = AW'(7);
    bus.cpu_wdata = 32'hA5;
    @(negedge clk);
    check("wr7_wEn", bus.ram_wEn, 1);
    check("wr7_addr", bus.ram_addr, 7);
    check("wr7_din", bus.ram_dataIn, 32'hA5);
    tick();
    idle();
    @(negedge clk);
    check("wr7_no_rvalid", bus.cpu_rvalid, 0);
    check("wr7_wEn_off", bus.ram_wEn, 0);
    tick();
    cpu_rd(7);
    tick();
    idle();
    @(negedge clk);
    check("rd7_rdata", bus.cpu_rdata, 32'hA5);

    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_rd(20);
    vga_rd(30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = bus.cpu_gnt;
      tick();
    end
    idle();
`ifdef VGA_PRIORITY_EN
    exp_pat = 10'b1000010000;
`else
    exp_pat = 10'b0101010101;
`endif
    check("tie_pattern", pat, exp_pat);
    tick();

    for (int i = 0; i < 8; i++) begin
      idle();
      if (i % 2 == 0) cpu_rd(40 + i);
      else vga_rd(40 + i);
      @(negedge clk);
      check("alt_one_gnt", bus.cpu_gnt ^ bus.vga_gnt, 1);
      tick();
    end
    idle();
    @(negedge clk);
    check("alt_vga_rvalid", bus.vga_rvalid, 1);
    check("alt_vga_rdata", bus.vga_rdata, 32'h102F);
    check("alt_cpu_rdata", bus.cpu_rdata, 32'h102E);
    tick();

    vga_rd(9);
    @(negedge clk);
    check("rst_rd_gnt", bus.vga_gnt, 1);
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    check("rst_rd_rvalid", bus.vga_rvalid, 0);
    check("rst_rd_rdata", bus.vga_rdata, 0);
    check("rst_rd_addr", bus.ram_addr, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd_no_rvalid", bus.vga_rvalid, 0);
    tick();
    @(negedge clk);
    check("rst_rd_still_0", bus.vga_rvalid, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
